seq_multiplier: RTL
===================

// Module: seq_multiplier
// PURPOSE
//  Parametrised multi-cycle shift-add multiplier; successor to the fixed 32-bit top-level multiply datapath.
//  Adds a valid/ready handshake on both sides, signed/unsigned mode per operation and a full double-width product.
//  Sits between the operand source (register file / test harness) and the result sink; one operation in flight.
// PARAMETERS
//  WIDTH  32  operand width in bits (>= 2); product is 2*WIDTH bits
// PORTS
//  clk        in   1        rising-edge clock, the only clock
//  reset      in   1        asynchronous, active-low reset (0 = reset asserted)
//  in_valid   in   1        operands and mode present on num1/num2/is_signed
//  in_ready   out  1        block can accept operands (IDLE only)
//  num1       in   WIDTH    multiplicand
//  num2       in   WIDTH    multiplier
//  is_signed  in   1        1 = two's-complement operands, 0 = unsigned
//  out_valid  out  1        result valid, held until accepted
//  out_ready  in   1        sink accepts result
//  result     out  2*WIDTH  product
//  busy       out  1        high in BUSY or DONE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal regs 0.
//  FSM: IDLE -> BUSY on in_valid&&in_ready at edge T; BUSY -> DONE after WIDTH BUSY cycles; DONE -> IDLE on out_valid&&out_ready.
//  IDLE: in_ready=1. On accept: latch is_signed; store |num1|, |num2| (magnitude when is_signed, raw otherwise) as WIDTH-bit unsigned; neg = is_signed & (num1[W-1]^num2[W-1]); clear accumulator; count=WIDTH.
//  BUSY: per cycle, if multiplier LSB=1 add multiplicand into upper half of 2*WIDTH+1-bit accumulator; shift accumulator right 1; shift multiplier right 1; count-1. in_ready=0; in_valid ignored.
//  No early termination: latency fixed. out_valid rises at edge T+WIDTH (WIDTH BUSY cycles), independent of operand values.
//  On BUSY->DONE edge: result <= neg ? -acc[2W-1:0] : acc[2W-1:0] (two's complement over 2*WIDTH bits).
//  DONE: out_valid=1, result stable, in_ready=0 for any number of out_ready=0 cycles. Accept edge: out_valid<=0, state<=IDLE, in_ready=1 next cycle; result keeps last value.
//  Back-to-back throughput: one op per WIDTH+2 cycles when out_ready tied high (accept, WIDTH BUSY, DONE).
//  Magnitude of -2^(W-1) is 2^(W-1) and fits WIDTH unsigned bits; no overflow possible in 2*WIDTH product.
//  Unsigned full-scale (2^W-1)^2 fits 2*WIDTH bits; accumulator carry bit is dropped after shift, never observed.
//  Operand changes while not in IDLE have no effect; reset asserted in any state aborts the op immediately, outputs return to reset values.
//  No X on outputs after reset; counter width $clog2(WIDTH+1).
// STRUCTURE
//  Shared package mul_pkg: typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t; helper function abs_w for magnitude.
//  Single module, no sub-module: FSM, counter, accumulator/multiplier shift register and sign-fix in one always_ff plus small always_comb.
// TESTING
//  1 WIDTH=32 unsigned 687 x 1245, out_ready=1 -> result=855315, out_valid exactly 32 cycles after accept edge.
//  2 signed -3 x 7 -> result=64'hFFFF_FFFF_FFFF_FFEB (-21); signed -2^31 x -2^31 -> 64'h4000_0000_0000_0000.
//  3 unsigned 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001; 0 x 32'h1234_5678 -> 0 at same latency.
//  4 backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/result stable, in_ready=0, new in_valid ignored; result changes only on next accepted op.
//  5 reset low mid-BUSY (cycle 10) -> same-cycle out_valid=0, result=0, in_ready=1 after release; next op 12 x 12 -> 144.
//  6 WIDTH=8 instance: unsigned 255 x 255 -> 65025; signed 8'h80 x 8'h7F -> 16'hC080 (-16256); latency 8.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

  // Widest operand abs_w can handle. Callers sign- or zero-extend into this width.
  localparam int MUL_MAX_W = 64;

  // Two's-complement magnitude of an already-extended operand. The magnitude
  // of the most negative WIDTH-bit value still fits WIDTH unsigned bits once
  // it is truncated back.
  function automatic logic [MUL_MAX_W-1:0] abs_w(input logic [MUL_MAX_W-1:0] v);
    return v[MUL_MAX_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with valid/ready on both sides and a
// signed/unsigned mode per operation. It has a fixed latency of WIDTH busy
// cycles and holds one operation at a time.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [MUL_MAX_W-1:0] ext1, ext2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     acc_nxt;
  logic [2*WIDTH-1:0]   prod, prod_fixed;

  // Operand magnitudes, one shift-add step and the final sign fix-up.
  always_comb begin
    ext1       = is_signed ? MUL_MAX_W'($signed(num1)) : MUL_MAX_W'(num1);
    ext2       = is_signed ? MUL_MAX_W'($signed(num2)) : MUL_MAX_W'(num2);
    mag1       = WIDTH'(abs_w(ext1));
    mag2       = WIDTH'(abs_w(ext2));
    // acc[2W] is always 0 between steps, so the top slice is a plain W-bit value
    sum        = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt    = {sum, acc[WIDTH-1:0]} >> 1;
    prod       = acc_nxt[2*WIDTH-1:0];
    prod_fixed = neg ? -prod : prod;
  end

  // FSM, counter, shift registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MUL_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (in_valid) begin
            mcand    <= mag1;
            mplier   <= mag2;
            neg      <= is_signed & (num1[WIDTH-1] ^ num2[WIDTH-1]);
            acc      <= '0;
            cnt      <= CW'(WIDTH);
            state    <= MUL_BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL_BUSY: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // No early exit: latency is WIDTH cycles regardless of the operands
          if (cnt == CW'(1)) begin
            state     <= MUL_DONE;
            out_valid <= 1'b1;
            result    <= prod_fixed;
          end
        end
        MUL_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= MUL_IDLE;
          end
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule
